stream_comparator: RTL and testbench

//   Parametrised, pipelined successor to the 16-bit magnitude comparator.

---
 rtl/cmp_pkg.sv | 13 +
 rtl/sat_counter.sv | 29 ++
 rtl/stream_comparator.sv | 88 ++++++++
 tb/tb_stream_comparator.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// rtl/cmp_pkg.sv - shared result encoding and defaults for the stream comparator
package cmp_pkg;

   typedef enum logic [1:0] {
      CMP_NONE,
      CMP_LT,
      CMP_EQ,
      CMP_GT
   } cmp_res_t;

   localparam int CMP_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear-then-increment priority
module sat_counter #(
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] count
);

   logic [CNT_WIDTH-1:0] r_count;
   logic                 w_full;

   assign w_full = &r_count;
   assign count  = r_count;

   // A clear coinciding with an increment leaves the counter at one, not zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_count <= '0;
      end else if (clear) begin
         r_count <= inc ? CNT_WIDTH'(1) : '0;
      end else if (inc && !w_full) begin
         r_count <= r_count + CNT_WIDTH'(1);
      end
   end

endmodule

// File: rtl/stream_comparator.sv
// rtl/stream_comparator.sv - handshaked signed/unsigned magnitude comparator with outcome tallies
module stream_comparator
   import cmp_pkg::*;
#(
   parameter int WIDTH     = CMP_DEFAULT_WIDTH,
   parameter int CNT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clear,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   input  logic                 signed_mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 gt,
   output logic                 lt,
   output logic                 eq,
   output logic [CNT_WIDTH-1:0] gt_count,
   output logic [CNT_WIDTH-1:0] lt_count,
   output logic [CNT_WIDTH-1:0] eq_count
);

   cmp_res_t r_res;
   logic     r_valid;
   cmp_res_t w_cmp;
   logic     w_accept;
   logic     w_lt;

   assign in_ready = !r_valid || out_ready;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_lt = signed_mode ? ($signed(a) < $signed(b)) : (a < b);
      w_cmp = CMP_GT;
      if (a == b) begin
         w_cmp = CMP_EQ;
      end else if (w_lt) begin
         w_cmp = CMP_LT;
      end
   end

   // Single output stage: load on accept, otherwise empty once the consumer takes it.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_res   <= CMP_NONE;
      end else if (w_accept) begin
         r_valid <= 1'b1;
         r_res   <= w_cmp;
      end else if (out_ready) begin
         r_valid <= 1'b0;
         r_res   <= CMP_NONE;
      end
   end

   assign out_valid = r_valid;
   assign gt        = (r_res == CMP_GT);
   assign lt        = (r_res == CMP_LT);
   assign eq        = (r_res == CMP_EQ);

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gt_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (w_accept && (w_cmp == CMP_GT)),
      .count (gt_count)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_lt_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (w_accept && (w_cmp == CMP_LT)),
      .count (lt_count)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_eq_cnt (
      .clk   (clk),
      .rst   (rst),
      .clear (clear),
      .inc   (w_accept && (w_cmp == CMP_EQ)),
      .count (eq_count)
   );

endmodule

// File: tb/tb_stream_comparator.sv
// tb/tb_stream_comparator.sv - directed self-checking bench for stream_comparator
module tb_stream_comparator;

   localparam int WIDTH     = 16;
   localparam int CNT_WIDTH = 2;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 clear;
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic                 signed_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic                 gt;
   logic                 lt;
   logic                 eq;
   logic [CNT_WIDTH-1:0] gt_count;
   logic [CNT_WIDTH-1:0] lt_count;
   logic [CNT_WIDTH-1:0] eq_count;

   int n_tests = 0;
   int n_fail  = 0;

   stream_comparator #(.WIDTH(WIDTH), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .clear       (clear),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .signed_mode (signed_mode),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .gt          (gt),
      .lt          (lt),
      .eq          (eq),
      .gt_count    (gt_count),
      .lt_count    (lt_count),
      .eq_count    (eq_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] flags();
      return {gt, lt, eq};
   endfunction

   // {gt,lt,eq} expected for each throughput vector, worked out by hand
   logic [WIDTH-1:0] tp_a   [8] = '{16'h0010, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h7FFF, 16'h1234, 16'h8000, 16'h0000};
   logic [WIDTH-1:0] tp_b   [8] = '{16'h0020, 16'h0001, 16'h0001, 16'h8000, 16'h8000, 16'h1234, 16'hFFFF, 16'h0000};
   logic             tp_sm  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
   logic [2:0]       tp_exp [8] = '{3'b010, 3'b010, 3'b100, 3'b100, 3'b010, 3'b001, 3'b010, 3'b001};
   int               sat_exp[5] = '{1, 2, 3, 3, 3};

   initial begin
      rst = 1'b1; clear = 1'b0; in_valid = 1'b1; a = 16'd5; b = 16'd3;
      signed_mode = 1'b0; out_ready = 1'b1;

      // Reset held with a valid pair presented
      for (int i = 0; i < 2; i++) begin
         cyc();
         chk("rst_out_valid", 32'(out_valid), 0);
         chk("rst_flags", 32'(flags()), 0);
         chk("rst_counts", {8'h0, 8'(gt_count), 8'(lt_count), 8'(eq_count)}, 0);
      end
      rst = 1'b0; in_valid = 1'b0;
      cyc();
      chk("rel_in_ready", 32'(in_ready), 1);
      chk("rel_out_valid", 32'(out_valid), 0);

      // Signed vs unsigned mode
      in_valid = 1'b1; a = 16'h8000; b = 16'h0001; signed_mode = 1'b0;
      cyc();
      chk("mode_u_valid", 32'(out_valid), 1);
      chk("mode_u_gt", 32'(flags()), 32'b100);
      signed_mode = 1'b1;
      cyc();
      chk("mode_s_lt", 32'(flags()), 32'b010);
      a = 16'hFFFF; b = 16'hFFFF;
      cyc();
      chk("mode_eq", 32'(flags()), 32'b001);
      in_valid = 1'b0;
      cyc();
      chk("drain_valid", 32'(out_valid), 0);
      chk("drain_flags", 32'(flags()), 0);
      chk("mode_counts", {8'h0, 8'(gt_count), 8'(lt_count), 8'(eq_count)}, 32'h00_01_01_01);

      // Backpressure
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      in_valid = 1'b1; a = 16'd5; b = 16'd3; signed_mode = 1'b0;
      cyc();
      chk("bp_first_gt", 32'(flags()), 32'b100);
      a = 16'd1; b = 16'd9; out_ready = 1'b0;
      #1;
      chk("bp_in_ready_low", 32'(in_ready), 0);
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("bp_hold_valid", 32'(out_valid), 1);
         chk("bp_hold_gt", 32'(flags()), 32'b100);
         chk("bp_hold_ready", 32'(in_ready), 0);
         chk("bp_gt_count", 32'(gt_count), 1);
      end
      out_ready = 1'b1;
      #1;
      chk("bp_in_ready_up", 32'(in_ready), 1);
      cyc();
      chk("bp_release_lt", 32'(flags()), 32'b010);
      chk("bp_lt_count", 32'(lt_count), 1);
      chk("bp_gt_count_end", 32'(gt_count), 1);
      in_valid = 1'b0;
      cyc();

      // Throughput: 8 back-to-back pairs
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a = tp_a[i]; b = tp_b[i]; signed_mode = tp_sm[i];
         cyc();
         chk($sformatf("tp_valid_%0d", i), 32'(out_valid), 1);
         chk($sformatf("tp_flags_%0d", i), 32'(flags()), 32'(tp_exp[i]));
      end
      in_valid = 1'b0;
      cyc();
      chk("tp_drain", 32'(out_valid), 0);
      chk("tp_lt_sat", 32'(lt_count), 3);
      chk("tp_gt_count", 32'(gt_count), 2);
      chk("tp_eq_count", 32'(eq_count), 2);

      // Saturation and clear-with-accept
      clear = 1'b1;
      cyc();
      clear = 1'b0;
      in_valid = 1'b1; a = 16'h0055; b = 16'h0055; signed_mode = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk($sformatf("sat_eq_%0d", i), 32'(eq_count), 32'(sat_exp[i]));
      end
      clear = 1'b1;
      cyc();
      chk("clr_acc_eq_count", 32'(eq_count), 1);
      chk("clr_acc_result", {31'h0, out_valid} << 3 | 32'(flags()), 32'b1001);
      clear = 1'b0; in_valid = 1'b0;
      cyc();

      // Reset mid-stream with a stalled result
      in_valid = 1'b1; a = 16'd5; b = 16'd3;
      cyc();
      out_ready = 1'b0; a = 16'd1; b = 16'd9; rst = 1'b1;
      cyc();
      chk("mid_rst_valid", 32'(out_valid), 0);
      chk("mid_rst_flags", 32'(flags()), 0);
      chk("mid_rst_counts", {8'h0, 8'(gt_count), 8'(lt_count), 8'(eq_count)}, 0);
      rst = 1'b0; in_valid = 1'b0;
      cyc();
      chk("post_rst_valid", 32'(out_valid), 0);
      chk("post_rst_flags", 32'(flags()), 0);
      out_ready = 1'b1;
      cyc();
      chk("post_rst_idle", 32'(out_valid), 0);
      chk("post_rst_counts", {8'h0, 8'(gt_count), 8'(lt_count), 8'(eq_count)}, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
